// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder used by serial_adder for its one-bit-per-cycle datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Combinational sum and carry of one bit position.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts a, b, cin on a valid/ready handshake, adds them
// LSB first through one full-adder cell, one bit per clock, and presents the
// result on a valid/ready output handshake.
// Optional: define SERIAL_ADDER_OVF_EN to add the signed-overflow port ovf.
//
// state | meaning
// IDLE  | waiting for an operand set (in_ready=1)
// RUN   | shifting operands through the full-adder cell, one bit per edge
// DONE  | result valid, held until out_ready
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    // Holds the partial sum; the newest bit enters at the top, so after all
    // bits the low WIDTH-1 result bits sit here and the last one joins above.
    logic [WIDTH-2:0] sum_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             out_valid_q;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_d;
    logic             last_bit;

`ifdef SERIAL_ADDER_OVF_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_q;
`endif

    fa_cell u_fa_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // Next partial-sum value and detection of the final bit position.
    always_comb begin
        sum_d    = {fa_s, sum_sh_q};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM plus datapath registers; results only update on the final bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        carry_q  <= cin;
                        sum_sh_q <= '0;
                        cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
`endif
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= fa_co;
                    sum_sh_q <= sum_d[WIDTH-1:1];
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        sum_q       <= sum_d;
                        cout_q      <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q       <= (a_msb_q == b_msb_q) & (fa_s != a_msb_q);
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Output drive; in_ready is a direct decode of the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = out_valid_q;
        sum       = sum_q;
        cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). A transaction-level model
// predicts in_ready/out_valid/sum/cout(/ovf) every cycle; directed tests add
// hand-computed literal expectations.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: busy from acceptance, result ready W edges later.
    logic         m_busy = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0;
    logic         m_cin = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [W:0]   m_full;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_cnt = 0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1; m_cnt = 0;
                m_a = a; m_b = b; m_cin = cin;
            end
        end else if (m_cnt < W) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == W) begin
                m_full = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
                m_sum  = m_full[W-1:0];
                m_cout = m_full[W];
                m_ovf  = (m_a[W-1] == m_b[W-1]) && (m_sum[W-1] != m_a[W-1]);
            end
        end else if (out_ready) begin
            m_busy = 1'b0;
        end
    end

    // Compare process against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("mdl_in_ready", in_ready, !m_busy);
            chk("mdl_out_valid", out_valid, m_busy && (m_cnt == W));
            chk("mdl_sum", sum, m_sum);
            chk("mdl_cout", cout, m_cout);
`ifdef SERIAL_ADDER_OVF_EN
            chk("mdl_ovf", ovf, m_ovf);
`endif
        end
    end

    // Drive one operand set and return just after the accepting edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // out_valid must be low after W-1 edges past acceptance and high after W.
    task automatic wait_result(input string name);
        repeat (W - 1) begin @(posedge clk); #1; end
        chk({name, "_early"}, out_valid, 1'b0);
        @(posedge clk); #1;
        chk({name, "_valid"}, out_valid, 1'b1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("rel_in_ready", in_ready, 1'b1);
        chk("rel_out_valid", out_valid, 1'b0);
    endtask

    task automatic op_lit(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
        start_op(ta, tb_v, tc);
        wait_result(name);
        chk({name, "_sum"}, sum, es);
        chk({name, "_cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk({name, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bx) chk({name, "_ovf_x"}, 0, 1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held_sum;
        logic         held_cout;

        #2;
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        op_lit("t0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        release_result();
        op_lit("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        release_result();
        op_lit("tffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        release_result();
        op_lit("t8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        release_result();
        op_lit("t7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // Stall in DONE for 20 cycles with in_valid pushing new data.
        held_sum = sum; held_cout = cout;
        in_valid = 1'b1; a = 8'h11; b = 8'h22;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_sum", sum, held_sum);
            chk("stall_cout", cout, held_cout);
        end
        in_valid = 1'b0;
        release_result();

        // Reset asserted at RUN bit 3.
        start_op(8'h33, 8'h44, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sum", sum, 8'h00);
        chk("mid_rst_cout", cout, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", out_valid, 1'b0);
        end
        op_lit("t55aa", 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);
        release_result();

        // Input noise during RUN must not disturb the accepted operands.
        start_op(8'h96, 8'h5A, 1'b1);
        for (int i = 1; i < W; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("noise_valid", out_valid, 1'b1);
        chk("noise_sum", sum, 8'hF1);
        chk("noise_cout", cout, 1'b0);
        release_result();

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
